// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one combinational-read RAM port between the CPU and an aux master.
// Fixed 3-cycle access (IDLE/ACCESS/DONE); requesters hold req until their one-cycle ack.
module mem_port_arbiter #(
  parameter int AW    = 12,
  parameter int DW    = 16,
  parameter int DEPTH = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          aux_req,
  input  logic          aux_we,
  input  logic [AW-1:0] aux_addr,
  input  logic [DW-1:0] aux_wdata,
  output logic          aux_ack,
  output logic [DW-1:0] aux_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          grant,
  output logic          oor_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [AW-1:0] LIMIT = AW'(DEPTH);

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic          grant_q, grant_d;
  logic          lat_we_q, lat_we_d;
  logic [AW-1:0] lat_addr_q, lat_addr_d;
  logic [DW-1:0] lat_wdata_q, lat_wdata_d;
  logic          mem_we_q, mem_we_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          aux_ack_q, aux_ack_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] aux_rdata_q, aux_rdata_d;
  logic          oor_q, oor_d;

  logic          any_req;
  logic          pick_aux;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          lat_in_range;
  logic [DW-1:0] rd_val;

  // last_q = 1 means aux was served last, so a tie goes to the CPU.
  assign any_req      = cpu_req | aux_req;
  assign pick_aux     = aux_req & (~cpu_req | ~last_q);
  assign sel_we       = pick_aux ? aux_we    : cpu_we;
  assign sel_addr     = pick_aux ? aux_addr  : cpu_addr;
  assign sel_wdata    = pick_aux ? aux_wdata : cpu_wdata;
  assign lat_in_range = lat_addr_q < LIMIT;
  assign rd_val       = lat_in_range ? mem_rdata : '0;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    lat_we_d    = lat_we_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    mem_we_d    = 1'b0;
    cpu_ack_d   = 1'b0;
    aux_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    aux_rdata_d = aux_rdata_q;
    oor_d       = oor_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d     = ST_ACCESS;
          last_d      = pick_aux;
          grant_d     = pick_aux;
          lat_we_d    = sel_we;
          lat_addr_d  = sel_addr;
          lat_wdata_d = sel_wdata;
          mem_we_d    = sel_we & (sel_addr < LIMIT);
        end
      end
      ST_ACCESS: begin
        state_d = ST_DONE;
        if (grant_q) aux_ack_d = 1'b1;
        else         cpu_ack_d = 1'b1;
        if (!lat_we_q) begin
          if (grant_q) aux_rdata_d = rd_val;
          else         cpu_rdata_d = rd_val;
        end
        if (!lat_in_range) oor_d = 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      grant_q     <= 1'b0;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      aux_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      aux_rdata_q <= '0;
      oor_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      lat_we_q    <= lat_we_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      mem_we_q    <= mem_we_d;
      cpu_ack_q   <= cpu_ack_d;
      aux_ack_q   <= aux_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      aux_rdata_q <= aux_rdata_d;
      oor_q       <= oor_d;
    end
  end

  assign mem_addr  = lat_addr_q;
  assign mem_wdata = lat_wdata_q;
  assign mem_we    = mem_we_q;
  assign cpu_ack   = cpu_ack_q;
  assign aux_ack   = aux_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign aux_rdata = aux_rdata_q;
  assign grant     = grant_q;
  assign oor_err   = oor_q;

endmodule
